// File: rtl/pll_vwire_hub_pkg.sv
// Shared constants and elaboration helpers for the PLL / virtual-wire hub.
//   ID_W       width of the instance tag at the top of the debug frame
//   frame_len  total debug chain length for a given probe/source width
//   div_of     integer clock ratio, or 0 when the ratio is not usable
package pll_vwire_pkg;

  localparam int ID_W = 32;

  function automatic int frame_len(input int pw, input int w);
    return pw + w + ID_W;
  endfunction

  // Returns 0 for a non-integer or sub-unity ratio; the caller turns a 0
  // into an elaboration error so a bad configuration never builds silently.
  function automatic int div_of(input int in_mhz, input int out_mhz);
    if (out_mhz <= 0 || in_mhz < out_mhz || (in_mhz % out_mhz) != 0)
      return 0;
    return in_mhz / out_mhz;
  endfunction

endpackage

// File: rtl/pll_vwire_hub_if.sv
// Serial debug chain signals between the host (master) and the hub (slave).
//   dbg_capture  load frame into shadow register
//   dbg_shift    shift shadow one bit toward LSB
//   dbg_update   copy shadow source field to source
//   dbg_tdi      serial data in, enters at MSB
//   dbg_tdo      serial data out = shadow[0]
interface pll_vwire_hub_if;
  logic dbg_capture;
  logic dbg_shift;
  logic dbg_update;
  logic dbg_tdi;
  logic dbg_tdo;

  modport master (
    output dbg_capture, dbg_shift, dbg_update, dbg_tdi,
    input  dbg_tdo
  );

  modport slave (
    input  dbg_capture, dbg_shift, dbg_update, dbg_tdi,
    output dbg_tdo
  );
endinterface

// File: rtl/pll_vwire_hub_clk_div_gen.sv
// Core clock divider and lock timer.
//   clk      board clock
//   rst_n    asynchronous active-low reset
//   clk_out  clk itself for DIV=1, otherwise a registered divide-by-DIV
//            waveform, low for the first ceil(DIV/2) counts
//   locked   rises LOCK_CYCLES clk edges after reset release, then stays high
module clk_div_gen #(
  parameter int DIV         = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic clk_out,
  output logic locked
);

  generate
    if (DIV == 1) begin : g_pass
      assign clk_out = clk;
    end else begin : g_div
      localparam int CW   = $clog2(DIV);
      localparam int HALF = (DIV + 1) / 2;

      logic [CW-1:0] cnt;
      logic [CW-1:0] cnt_nxt;
      logic          clk_q;

      always_comb begin
        cnt_nxt = cnt + CW'(1);
        if (cnt == CW'(DIV - 1))
          cnt_nxt = '0;
      end

      // clk_q is computed from the next count so it always matches the
      // count held in cnt, keeping the output glitch-free and in phase.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt   <= '0;
          clk_q <= 1'b0;
        end else begin
          cnt   <= cnt_nxt;
          clk_q <= (cnt_nxt >= CW'(HALF));
        end
      end

      assign clk_out = clk_q;
    end
  endgenerate

  // Lock timer: down-counter loaded at reset, terminal count sets locked.
  localparam int LW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;

  logic [LW-1:0] lock_cnt;
  logic          locked_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_cnt <= LW'(LOCK_CYCLES);
      locked_q <= 1'b0;
    end else begin
      if (lock_cnt != '0)
        lock_cnt <= lock_cnt - LW'(1);
      locked_q <= locked_q | (lock_cnt <= LW'(1));
    end
  end

  assign locked = locked_q;

endmodule

// File: rtl/pll_vwire_hub.sv
// Clock-generation and debug-visibility hub.
//   clk      board clock (only clock)       rst_n   async active-low reset
//   clk_out  derived core clock             locked  clk_out stable
//   probe    value sampled on capture       source  host-written value
//   dbg      serial debug chain (slave side)
// Frame layout LSB->MSB: probe, source (WIDTH bits, absent when 0), INSTANCE_ID.
// Debug priority on a single edge: capture > update > shift.
module pll_vwire_hub
  import pll_vwire_pkg::*;
#(
  parameter int                               IN_MHZ      = 50,
  parameter int                               SPEED_MHZ   = 50,
  parameter int                               LOCK_CYCLES = 16,
  parameter int                               PROBE_WIDTH = 32,
  parameter int                               WIDTH       = 0,
  parameter logic [ID_W-1:0]                  INSTANCE_ID = "QONE",
  parameter logic [((WIDTH > 0) ? WIDTH : 1)-1:0] SOURCE_INIT = '0
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  output logic                                 clk_out,
  output logic                                 locked,
  input  logic [PROBE_WIDTH-1:0]               probe,
  output logic [((WIDTH > 0) ? WIDTH : 1)-1:0] source,
  pll_vwire_hub_if.slave                       dbg
);

  localparam int DIV = div_of(IN_MHZ, SPEED_MHZ);
  localparam int N   = frame_len(PROBE_WIDTH, WIDTH);

  generate
    if (DIV < 1) begin : g_bad_div
      $error("pll_vwire_hub: IN_MHZ/SPEED_MHZ must be an integer >= 1");
    end
    if (PROBE_WIDTH < 1) begin : g_bad_probe
      $error("pll_vwire_hub: PROBE_WIDTH must be >= 1");
    end
  endgenerate

  clk_div_gen #(
    .DIV         (DIV),
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_clk_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_out (clk_out),
    .locked  (locked)
  );

  logic [N-1:0] shadow;
  logic [N-1:0] cap_frame;

  generate
    if (WIDTH > 0) begin : g_src
      logic [WIDTH-1:0] src_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          src_q <= SOURCE_INIT;
        else if (dbg.dbg_update && !dbg.dbg_capture)
          src_q <= shadow[PROBE_WIDTH +: WIDTH];
      end

      assign source    = src_q;
      assign cap_frame = {INSTANCE_ID, src_q, probe};
    end else begin : g_nosrc
      assign source    = '0;
      assign cap_frame = {INSTANCE_ID, probe};
    end
  endgenerate

  // An update edge freezes the shadow so a coincident shift cannot move the
  // field being copied out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      shadow <= '0;
    else if (dbg.dbg_capture)
      shadow <= cap_frame;
    else if (dbg.dbg_shift && !dbg.dbg_update)
      shadow <= {dbg.dbg_tdi, shadow[N-1:1]};
  end

  assign dbg.dbg_tdo = shadow[0];

endmodule

// File: tb/tb_pll_vwire_hub.sv
// Directed bench for pll_vwire_hub: three instances cover DIV=1 (no source),
// DIV=2 with an 8-bit source, and DIV=5 with a narrow probe.
module tb_pll_vwire_hub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        clk_out_a, locked_a, source_a;
  logic        clk_out_b, locked_b;
  logic        clk_out_c, locked_c, source_c;
  logic [31:0] probe_a, probe_b;
  logic [3:0]  probe_c;
  logic [7:0]  source_b;

  pll_vwire_hub_if if_a ();
  pll_vwire_hub_if if_b ();
  pll_vwire_hub_if if_c ();

  pll_vwire_hub #(
    .IN_MHZ (50), .SPEED_MHZ (50), .PROBE_WIDTH (32), .WIDTH (0)
  ) u_a (
    .clk (clk), .rst_n (rst_n), .clk_out (clk_out_a), .locked (locked_a),
    .probe (probe_a), .source (source_a), .dbg (if_a.slave)
  );

  pll_vwire_hub #(
    .IN_MHZ (50), .SPEED_MHZ (25), .PROBE_WIDTH (32), .WIDTH (8),
    .INSTANCE_ID ("PLLB"), .SOURCE_INIT (8'h3C)
  ) u_b (
    .clk (clk), .rst_n (rst_n), .clk_out (clk_out_b), .locked (locked_b),
    .probe (probe_b), .source (source_b), .dbg (if_b.slave)
  );

  pll_vwire_hub #(
    .IN_MHZ (50), .SPEED_MHZ (10), .PROBE_WIDTH (4), .WIDTH (0)
  ) u_c (
    .clk (clk), .rst_n (rst_n), .clk_out (clk_out_c), .locked (locked_c),
    .probe (probe_c), .source (source_c), .dbg (if_c.slave)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  logic [63:0] exp_a, got_a;
  logic [71:0] frame_in, got_b;

  initial begin
    if_a.dbg_capture = 0; if_a.dbg_shift = 0; if_a.dbg_update = 0; if_a.dbg_tdi = 0;
    if_b.dbg_capture = 0; if_b.dbg_shift = 0; if_b.dbg_update = 0; if_b.dbg_tdi = 0;
    if_c.dbg_capture = 0; if_c.dbg_shift = 0; if_c.dbg_update = 0; if_c.dbg_tdi = 0;
    probe_a = 32'h001D_83C0;
    probe_b = 32'hDEAD_BEEF;
    probe_c = 4'h9;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_locked_a", locked_a, 0);
    check("rst_locked_b", locked_b, 0);
    check("rst_locked_c", locked_c, 0);
    check("rst_clk_out_b", clk_out_b, 0);
    check("rst_clk_out_c", clk_out_c, 0);
    check("rst_source_a", source_a, 0);
    check("rst_source_b", source_b, 8'h3C);
    check("rst_tdo_a", if_a.dbg_tdo, 0);
    check("rst_tdo_b", if_b.dbg_tdo, 0);

    // Lock after exactly 16 edges; divider phase k%DIV after edge k
    rst_n = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k == 15) begin
        check("lock_early_a", locked_a, 0);
        check("lock_early_b", locked_b, 0);
        check("lock_early_c", locked_c, 0);
      end
      if (k == 16) begin
        check("lock_a", locked_a, 1);
        check("lock_b", locked_b, 1);
        check("lock_c", locked_c, 1);
      end
      if (k >= 17) begin
        check("div2_clk_out", clk_out_b, 128'(k % 2));
        check("div5_clk_out", clk_out_c, 128'((k % 5) >= 3));
      end
    end

    // DIV=1 pass-through
    check("div1_low", clk_out_a, 0);
    @(posedge clk); #1;
    check("div1_high", clk_out_a, 1);

    // Capture and shift out 64 bits from instance a
    @(negedge clk);
    if_a.dbg_capture = 1;
    @(negedge clk);
    if_a.dbg_capture = 0;
    exp_a = {32'h514F_4E45, 32'h001D_83C0};
    for (int i = 0; i < 64; i++) begin
      got_a[i] = if_a.dbg_tdo;
      if_a.dbg_shift = 1;
      @(negedge clk);
    end
    if_a.dbg_shift = 0;
    check("a_frame", got_a, exp_a);
    check("a_source_const", source_a, 0);

    // Shift a host frame with source field A5 into instance b
    frame_in = {32'h0, 8'hA5, 32'h0};
    for (int i = 0; i < 72; i++) begin
      if_b.dbg_tdi = frame_in[i];
      if_b.dbg_shift = 1;
      @(negedge clk);
    end
    if_b.dbg_shift = 0;
    if_b.dbg_tdi = 0;
    check("b_src_before_upd", source_b, 8'h3C);
    if_b.dbg_update = 1;
    @(negedge clk);
    if_b.dbg_update = 0;
    check("b_src_after_upd", source_b, 8'hA5);

    if_b.dbg_capture = 1;
    @(negedge clk);
    if_b.dbg_capture = 0;
    for (int i = 0; i < 72; i++) begin
      got_b[i] = if_b.dbg_tdo;
      if_b.dbg_shift = 1;
      @(negedge clk);
    end
    if_b.dbg_shift = 0;
    check("b_recapture", got_b, {32'h504C_4C42, 8'hA5, 32'hDEAD_BEEF});
    check("b_recapture_src", got_b[39:32], 8'hA5);

    // Capture, update and shift together: only capture takes effect
    probe_b = 32'h1234_5678;
    if_b.dbg_capture = 1; if_b.dbg_update = 1; if_b.dbg_shift = 1; if_b.dbg_tdi = 1;
    @(negedge clk);
    if_b.dbg_capture = 0; if_b.dbg_update = 0; if_b.dbg_shift = 0; if_b.dbg_tdi = 0;
    check("prio_src_kept", source_b, 8'hA5);
    for (int i = 0; i < 72; i++) begin
      got_b[i] = if_b.dbg_tdo;
      if_b.dbg_shift = 1;
      @(negedge clk);
    end
    if_b.dbg_shift = 0;
    check("prio_frame", got_b, {32'h504C_4C42, 8'hA5, 32'h1234_5678});

    // Reset after 10 shifts of a fresh capture
    if_b.dbg_capture = 1;
    @(negedge clk);
    if_b.dbg_capture = 0;
    if_b.dbg_shift = 1;
    repeat (10) @(negedge clk);
    if_b.dbg_shift = 0;
    check("pre_rst_tdo_b", if_b.dbg_tdo, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_src_b", source_b, 8'h3C);
    check("mid_rst_tdo_b", if_b.dbg_tdo, 0);
    check("mid_rst_locked_a", locked_a, 0);
    check("mid_rst_locked_b", locked_b, 0);
    check("mid_rst_clk_out_b", clk_out_b, 0);
    check("mid_rst_clk_out_c", clk_out_c, 0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 15) check("relock_early_b", locked_b, 0);
      if (k == 16) begin
        check("relock_a", locked_a, 1);
        check("relock_b", locked_b, 1);
      end
    end

    for (int i = 0; i < 72; i++) begin
      got_b[i] = if_b.dbg_tdo;
      if_b.dbg_shift = 1;
      @(negedge clk);
    end
    if_b.dbg_shift = 0;
    check("post_rst_shadow", got_b, 0);
    check("post_rst_src_b", source_b, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
